// File: rtl/fir_mac_if.sv
// Bus bundle between the FIR MAC sequencer and its environment: sample input,
// coefficient port, shared multiplier operands and the filtered output.
interface fir_mac_if #(
    parameter int N  = 16,
    parameter int AW = 3
);
    logic          sample_valid;
    logic [N-1:0]  sample_in;
    logic          sample_ready;
    logic          overrun;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data;
    logic          coef_err;
    logic [N-1:0]  mult_a;
    logic [N-1:0]  mult_b;
    logic [N-1:0]  mult_result;
    logic          out_valid;
    logic [N-1:0]  out_sample;

    modport master (
        output sample_valid, sample_in, coef_we, coef_addr, coef_data, mult_result,
        input  sample_ready, overrun, coef_err, mult_a, mult_b, out_valid, out_sample
    );

    modport slave (
        input  sample_valid, sample_in, coef_we, coef_addr, coef_data, mult_result,
        output sample_ready, overrun, coef_err, mult_a, mult_b, out_valid, out_sample
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed direct-form FIR controller: owns delay line and coefficients,
// drives one shared saturating multiplier for TAPS cycles per accepted sample.
module fir_mac_sequencer #(
    parameter int N    = 16,
    parameter int TAPS = 8,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic       clk,
    input  logic       rst,
    fir_mac_if.slave   bus
);
    localparam int ACC_W = N + AW;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (N-1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                   state_q;
    logic [AW-1:0]            idx_q;
    logic [N-1:0]             dly_q  [TAPS];
    logic [N-1:0]             coef_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [N-1:0]             out_sample_q;
    logic [N-1:0]             out_sample_d;
    logic                     out_valid_q;
    logic                     overrun_q;
    logic                     coef_err_q;
    logic                     busy_s;

    // Negative clip is symmetric (-max) to match the multiplier's saturation.
    function automatic logic [N-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
        logic [N-1:0] r;
        if (a > ACC_MAX) begin
            r = {1'b0, {(N-1){1'b1}}};
        end else if (a < ACC_MIN) begin
            r = {1'b1, {(N-2){1'b0}}, 1'b1};
        end else begin
            r = a[N-1:0];
        end
        return r;
    endfunction

    assign busy_s       = (state_q != S_IDLE);
    assign acc_d        = acc_q + $signed({{AW{bus.mult_result[N-1]}}, bus.mult_result});
    assign out_sample_d = sat_acc(acc_q);

    assign bus.mult_a       = (state_q == S_MAC) ? dly_q[idx_q]  : {N{1'b0}};
    assign bus.mult_b       = (state_q == S_MAC) ? coef_q[idx_q] : {N{1'b0}};
    assign bus.sample_ready = (state_q == S_IDLE);
    assign bus.out_sample   = out_sample_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.coef_err     = coef_err_q;

    // Sequencer FSM with delay line, coefficient bank, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= {AW{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            out_sample_q <= {N{1'b0}};
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            coef_err_q   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dly_q[k]  <= {N{1'b0}};
                coef_q[k] <= {N{1'b0}};
            end
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= busy_s & bus.sample_valid;
            coef_err_q  <= busy_s & bus.coef_we;
            case (state_q)
                S_IDLE: begin
                    if (bus.coef_we) begin
                        coef_q[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.sample_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            dly_q[k] <= dly_q[k-1];
                        end
                        dly_q[0] <= bus.sample_in;
                        acc_q    <= {ACC_W{1'b0}};
                        idx_q    <= {AW{1'b0}};
                        state_q  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                S_DONE: begin
                    out_sample_q <= out_sample_d;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed direct-form FIR controller for the filter datapath.
- Owns the sample delay line and the coefficient bank, and feeds one shared external signed fixed-point multiplier for TAPS cycles per input sample.
- The multiplier is signed two's complement, Q(N/2).(N/2), combinational, with saturating products.
- Accumulates the products with guard bits and emits one saturated N-bit filtered sample per accepted input.

Parameters:
- N, 16, sample/coefficient/product width; Q(N/2).(N/2) two's complement.
- TAPS, 8, number of filter taps (power of two, >=2).
- AW, $clog2(TAPS), tap index / coefficient address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  single-cycle strobe: sample_in is valid.
- sample_in  in  N  new input sample.
- sample_ready  out  1  high when an input sample can be accepted (state IDLE).
- overrun  out  1  one-cycle pulse: sample_valid arrived while not ready; that sample is dropped.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  AW  coefficient index, 0 = newest-sample tap.
- coef_data  in  N  coefficient value.
- coef_err  out  1  one-cycle pulse: coef_we arrived while busy; the write is ignored.
- mult_a  out  N  multiplier operand A (delay-line sample).
- mult_b  out  N  multiplier operand B (coefficient).
- mult_result  in  N  saturated product from the shared multiplier, same cycle.
- out_valid  out  1  one-cycle pulse: out_sample holds a new result.
- out_sample  out  N  filtered sample, saturated; holds until the next result.

Behaviour:
- Reset (async, any state, including mid-MAC):
  - state goes to IDLE; delay line, coefficients, accumulator and tap index all clear to 0.
  - out_sample=0, out_valid=0, overrun=0, coef_err=0, mult_a=0, mult_b=0, sample_ready=1 after reset deassert.
  - An aborted MAC produces no out_valid.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - sample_valid=1: on that edge, shift the delay line (d[k]<=d[k-1], d[0]<=sample_in), clear acc, set idx=0, go to MAC.
  - coef_we is honoured only in IDLE (coef[coef_addr]<=coef_data).
  - If sample_valid and coef_we occur in the same cycle, both happen.
- MAC (TAPS cycles):
  - mult_a=d[idx], mult_b=coef[idx] combinationally from registered idx.
  - Each edge: acc <= acc + sign_extend(mult_result); idx++.
  - Transition to DONE on the edge where idx==TAPS-1.
- DONE (1 cycle):
  - out_sample <= sat(acc), out_valid=1, go to IDLE.
  - Therefore out_valid asserts in the cycle TAPS+1 clocks after the accept edge; throughput is 1 sample per TAPS+2 cycles.
- Outside MAC, mult_a=mult_b=0.
- Arithmetic:
  - acc is signed, N+AW bits, and cannot overflow internally.
  - sat(acc): acc > 0x7FFF (N-bit max) gives 0x7FFF; acc < -0x7FFF gives 0x8001 (symmetric, matching multiplier negative saturation); otherwise acc[N-1:0].
  - acc == 0 gives 0x0000.
- Busy rules:
  - sample_valid while state != IDLE: sample dropped, delay line unchanged, overrun pulses the next cycle.
  - coef_we while state != IDLE: ignored, coef_err pulses the next cycle.
- idx wraps to 0 only via the IDLE accept path; it never runs past TAPS-1.

Test Plan:
- Reset, all coef=0x0020 (0.125), impulse 0x0100 then 0x0000 samples -> out_sample=0x0020 for 8 results, then 0x0000; each out_valid exactly 9 cycles after accept.
- Same coefs, constant step 0x0100 -> outputs 0x0020, 0x0040, ..., 0x0100 (8th result), steady at 0x0100.
- All coef=0x7F00, samples 0x7F00 -> products saturate 0x7FFF, sum saturates -> out_sample=0x7FFF; with samples 0x8100 -> 0x8001.
- sample_valid strobed at cycle 3 of MAC -> overrun=1 next cycle, result identical to the no-strobe case, sample_ready=0 throughout MAC/DONE; coef_we during MAC -> coef_err pulse, coefficient unchanged on readback via the impulse response.
- Assert rst at MAC idx=4 -> no out_valid, out_sample=0x0000, sample_ready=1 after release; the next impulse yields 0x0000 (coefs cleared).
- Simultaneous sample_valid and coef_we in IDLE (addr 0, data 0x0100, sample 0x0100, others 0) -> out_sample=0x0100.
